capture_scheduler: RTL

Frame-capture sequencer for up to two Stonyman imager channels (cam0, cam1). It issues frame_capture_start pulses to each channel's stonyman controller, round-robin between enabled cameras, and paces captures to a programmed frame period. It supervises each frame with a completion timeout and pulses the per-camera soft reset on timeout or abort. It sits between the imager APB register block and the per-camera controllers and replaces direct software-driven capture start.

---
 rtl/capture_scheduler_if.sv | 42 ++++
 rtl/capture_scheduler.sv | 115 +++++++++++
 2 files changed

// File: rtl/capture_scheduler_if.sv
// capture_scheduler_if: control, status and per-camera handshake bundle of the capture scheduler
interface capture_scheduler_if #(parameter int PERIOD_WIDTH = 24);
  logic enable;
  logic continuous;
  logic start;
  logic abort;
  logic clear_errors;
  logic [1:0] cam_enable;
  logic [PERIOD_WIDTH-1:0] period;
  logic cam0_controller_busy;
  logic cam1_controller_busy;
  logic cam0_frame_capture_done;
  logic cam1_frame_capture_done;
  logic cam0_fifo_overflow;
  logic cam1_fifo_overflow;
  logic cam0_frame_capture_start;
  logic cam1_frame_capture_start;
  logic cam0_reset;
  logic cam1_reset;
  logic busy;
  logic active_cam;
  logic [15:0] frame_count;
  logic round_done;
  logic error_timeout;
  logic error_overflow;
  modport master (
    input enable, continuous, start, abort, clear_errors, cam_enable, period,
    input cam0_controller_busy, cam1_controller_busy,
    input cam0_frame_capture_done, cam1_frame_capture_done,
    input cam0_fifo_overflow, cam1_fifo_overflow,
    output cam0_frame_capture_start, cam1_frame_capture_start, cam0_reset, cam1_reset,
    output busy, active_cam, frame_count, round_done, error_timeout, error_overflow
  );
  modport slave (
    output enable, continuous, start, abort, clear_errors, cam_enable, period,
    output cam0_controller_busy, cam1_controller_busy,
    output cam0_frame_capture_done, cam1_frame_capture_done,
    output cam0_fifo_overflow, cam1_fifo_overflow,
    input cam0_frame_capture_start, cam1_frame_capture_start, cam0_reset, cam1_reset,
    input busy, active_cam, frame_count, round_done, error_timeout, error_overflow
  );
endinterface

// File: rtl/capture_scheduler.sv
// capture_scheduler: round-robin frame-capture sequencer with period pacing, timeout supervision and reset recovery
module capture_scheduler #(
  parameter int PERIOD_WIDTH = 24,
  parameter int TIMEOUT_WIDTH = 24,
  parameter int RESET_CYCLES = 4
) (
  input logic clk,
  input logic reset_n,
  capture_scheduler_if.master bus
);
  localparam int RW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, SELECT, WAIT_PERIOD, ISSUE, WAIT_DONE, RECOVER} state_t;
  state_t state;
  logic [PERIOD_WIDTH-1:0] period_cnt;
  logic [TIMEOUT_WIDTH-1:0] tcnt, tcnt_inc;
  logic [RW-1:0] rcnt;
  logic [15:0] frame_count;
  logic [1:0] served, served_n, start_q, reset_q, busy_v, done_v, ovf_v;
  logic cam, last_cam, round_done, err_t, err_o;
  logic pick, more, ready, tmo, go_rec, set_t, set_o;
  assign busy_v = {bus.cam1_controller_busy, bus.cam0_controller_busy};
  assign done_v = {bus.cam1_frame_capture_done, bus.cam0_frame_capture_done};
  assign ovf_v = {bus.cam1_fifo_overflow, bus.cam0_fifo_overflow};
  assign pick = bus.cam_enable[~last_cam] ? ~last_cam : last_cam;
  assign served_n = served | (2'b01 << cam);
  assign more = bus.cam_enable[~cam] && !served_n[~cam];
  // two cycles of lookahead cover the ISSUE cycle and the registered start, so pulses land exactly period apart
  assign ready = ({2'b00, period_cnt} + (PERIOD_WIDTH+2)'(2)) >= {2'b00, bus.period};
  assign tcnt_inc = tcnt + TIMEOUT_WIDTH'(1);
  assign tmo = &tcnt_inc;
  assign go_rec = bus.abort && (state inside {SELECT, WAIT_PERIOD, ISSUE, WAIT_DONE});
  assign set_t = state == WAIT_DONE && !go_rec && !done_v[cam] && tmo;
  assign set_o = state == WAIT_DONE && ovf_v[cam];
  assign bus.cam0_frame_capture_start = start_q[0];
  assign bus.cam1_frame_capture_start = start_q[1];
  assign bus.cam0_reset = reset_q[0];
  assign bus.cam1_reset = reset_q[1];
  assign bus.busy = state != IDLE;
  assign bus.active_cam = cam;
  assign bus.frame_count = frame_count;
  assign bus.round_done = round_done;
  assign bus.error_timeout = err_t;
  assign bus.error_overflow = err_o;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      period_cnt <= '1;
      tcnt <= '0;
      rcnt <= '0;
      frame_count <= '0;
      served <= '0;
      start_q <= '0;
      reset_q <= '0;
      cam <= 1'b0;
      last_cam <= 1'b1;
      round_done <= 1'b0;
      err_t <= 1'b0;
      err_o <= 1'b0;
    end else begin
      start_q <= '0;
      round_done <= 1'b0;
      period_cnt <= &period_cnt ? period_cnt : period_cnt + PERIOD_WIDTH'(1);
      err_t <= set_t | (err_t & ~bus.clear_errors);
      err_o <= set_o | (err_o & ~bus.clear_errors);
      if (go_rec) begin
        state <= RECOVER;
        reset_q[cam] <= 1'b1;
        rcnt <= '0;
      end else begin
        case (state)
          IDLE: if (bus.start && bus.enable && |bus.cam_enable) begin
            state <= SELECT;
            served <= '0;
          end
          SELECT: if (!bus.enable || bus.cam_enable == 2'b00) state <= IDLE;
          else begin
            cam <= pick;
            state <= WAIT_PERIOD;
          end
          WAIT_PERIOD: state <= !bus.enable ? IDLE : ready ? ISSUE : WAIT_PERIOD;
          ISSUE: if (!bus.enable) state <= IDLE;
          else if (!busy_v[cam]) begin
            start_q[cam] <= 1'b1;
            period_cnt <= '0;
            tcnt <= '0;
            state <= WAIT_DONE;
          end
          WAIT_DONE: if (done_v[cam]) begin
            frame_count <= frame_count + 16'd1;
            last_cam <= cam;
            if (bus.enable && more) begin
              served <= served_n;
              state <= SELECT;
            end else if (bus.enable && bus.continuous) begin
              served <= '0;
              state <= SELECT;
            end else begin
              round_done <= 1'b1;
              state <= IDLE;
            end
          end else if (tmo) begin
            state <= RECOVER;
            reset_q[cam] <= 1'b1;
            rcnt <= '0;
          end else tcnt <= tcnt_inc;
          RECOVER: if (rcnt == RW'(RESET_CYCLES - 1)) begin
            reset_q <= '0;
            state <= IDLE;
          end else rcnt <= rcnt + RW'(1);
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
